// File: rtl/range_counter.sv
// range_counter: wrapping up-counter from COUNT_FROM to COUNT_TO in steps of STEP.
// Optional macro COUNTER_WRAP_PULSE_EN adds a registered one-cycle wrap output.
module range_counter #(
  parameter                     ARCHITECTURE = "BEHAVIORAL",
  parameter int unsigned        DATA_WIDTH   = 8,
  parameter longint unsigned    COUNT_FROM   = 0,
  parameter longint unsigned    COUNT_TO     = 255,
  parameter longint unsigned    STEP         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] out
`ifdef COUNTER_WRAP_PULSE_EN
  ,
  output logic                  wrap
`endif
);

  localparam int unsigned SW = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] FROM_V = DATA_WIDTH'(COUNT_FROM);

  // Elaboration-time parameter legality
  if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_chk_width
    $fatal(1, "range_counter: DATA_WIDTH must be 1..64");
  end
  if (COUNT_FROM > COUNT_TO) begin : g_chk_order
    $fatal(1, "range_counter: COUNT_FROM must be <= COUNT_TO");
  end
  if ((65'(COUNT_TO) >> DATA_WIDTH) != 65'd0) begin : g_chk_to
    $fatal(1, "range_counter: COUNT_TO must fit in DATA_WIDTH bits");
  end
  if (STEP < 1) begin : g_chk_step_lo
    $fatal(1, "range_counter: STEP must be >= 1");
  end
  if ((65'(STEP) >> DATA_WIDTH) != 65'd0) begin : g_chk_step_hi
    $fatal(1, "range_counter: STEP must be <= 2^DATA_WIDTH-1");
  end

  // Power-up value matches reset value so the counter works without a reset
  logic [DATA_WIDTH-1:0] cnt_q = FROM_V;
  logic [DATA_WIDTH-1:0] cnt_d;
  logic [SW-1:0]         sum;
  logic                  over;

  if (ARCHITECTURE == "BEHAVIORAL") begin : g_beh
    assign sum  = {1'b0, cnt_q} + SW'(STEP);
    assign over = sum > SW'(COUNT_TO);
  end else if (ARCHITECTURE == "STRUCTURAL") begin : g_str
    logic [SW-1:0] add_a;
    logic [SW-1:0] add_b;
    logic [SW-1:0] cmp_x;
    logic [SW-1:0] carry;
    logic [SW:0]   borrow;

    assign add_a     = {1'b0, cnt_q};
    assign add_b     = SW'(STEP);
    assign cmp_x     = SW'(COUNT_TO);
    assign carry[0]  = 1'b0;
    assign borrow[0] = 1'b0;

    // Ripple adder; the comparator is the borrow chain of COUNT_TO - sum
    for (genvar i = 0; i < SW; i++) begin : g_bit
      assign sum[i] = add_a[i] ^ add_b[i] ^ carry[i];
      if (i + 1 < SW) begin : g_carry
        assign carry[i+1] = (add_a[i] & add_b[i]) | (carry[i] & (add_a[i] ^ add_b[i]));
      end
      assign borrow[i+1] = (~cmp_x[i] & sum[i]) | (~(cmp_x[i] ^ sum[i]) & borrow[i]);
    end
    assign over = borrow[SW];
  end else begin : g_bad_arch
    $fatal(1, "range_counter: ARCHITECTURE must be BEHAVIORAL or STRUCTURAL");
  end

`ifdef COUNTER_WRAP_PULSE_EN
  logic wrap_q = 1'b0;
  logic wrap_d;
`endif

  // Next-state
  always_comb begin
    cnt_d = cnt_q;
`ifdef COUNTER_WRAP_PULSE_EN
    wrap_d = 1'b0;
`endif
    if (en) begin
      if (over) begin
        cnt_d = FROM_V;
`ifdef COUNTER_WRAP_PULSE_EN
        wrap_d = 1'b1;
`endif
      end else begin
        cnt_d = sum[DATA_WIDTH-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= FROM_V;
`ifdef COUNTER_WRAP_PULSE_EN
      wrap_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
`ifdef COUNTER_WRAP_PULSE_EN
      wrap_q <= wrap_d;
`endif
    end
  end

  assign out = cnt_q;
`ifdef COUNTER_WRAP_PULSE_EN
  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_range_counter.sv
// tb_range_counter: random and directed stimulus on three parameter sets in both
// architectures, checked against an index-based model (value = FROM + k*STEP).
module tb_range_counter;

  // Parameter sets: defaults; 3..20 step 5; 4-bit 0..15 step 3
  localparam longint unsigned F0 = 0,  T0 = 255, S0 = 1;
  localparam longint unsigned F1 = 3,  T1 = 20,  S1 = 5;
  localparam longint unsigned F2 = 0,  T2 = 15,  S2 = 3;
  // Number of steps in one pass before the wrap
  localparam longint unsigned K0 = (T0 - F0) / S0;
  localparam longint unsigned K1 = (T1 - F1) / S1;
  localparam longint unsigned K2 = (T2 - F2) / S2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic [7:0] o0b, o0s, o1b, o1s;
  logic [3:0] o2b, o2s;
  logic w0b, w0s, w1b, w1s, w2b, w2s;

  int n_tests = 0;
  int n_fail  = 0;
  longint unsigned k0 = 0, k1 = 0, k2 = 0;
  logic xw0 = 1'b0, xw1 = 1'b0, xw2 = 1'b0;

  always #5 clk = ~clk;

  range_counter #(.ARCHITECTURE("BEHAVIORAL")) u0b (.clk(clk), .rst(rst), .en(en), .out(o0b)
`ifdef COUNTER_WRAP_PULSE_EN
    , .wrap(w0b)
`endif
  );
  range_counter #(.ARCHITECTURE("STRUCTURAL")) u0s (.clk(clk), .rst(rst), .en(en), .out(o0s)
`ifdef COUNTER_WRAP_PULSE_EN
    , .wrap(w0s)
`endif
  );
  range_counter #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(8), .COUNT_FROM(F1), .COUNT_TO(T1),
                  .STEP(S1)) u1b (.clk(clk), .rst(rst), .en(en), .out(o1b)
`ifdef COUNTER_WRAP_PULSE_EN
    , .wrap(w1b)
`endif
  );
  range_counter #(.ARCHITECTURE("STRUCTURAL"), .DATA_WIDTH(8), .COUNT_FROM(F1), .COUNT_TO(T1),
                  .STEP(S1)) u1s (.clk(clk), .rst(rst), .en(en), .out(o1s)
`ifdef COUNTER_WRAP_PULSE_EN
    , .wrap(w1s)
`endif
  );
  range_counter #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(4), .COUNT_FROM(F2), .COUNT_TO(T2),
                  .STEP(S2)) u2b (.clk(clk), .rst(rst), .en(en), .out(o2b)
`ifdef COUNTER_WRAP_PULSE_EN
    , .wrap(w2b)
`endif
  );
  range_counter #(.ARCHITECTURE("STRUCTURAL"), .DATA_WIDTH(4), .COUNT_FROM(F2), .COUNT_TO(T2),
                  .STEP(S2)) u2s (.clk(clk), .rst(rst), .en(en), .out(o2s)
`ifdef COUNTER_WRAP_PULSE_EN
    , .wrap(w2s)
`endif
  );

`ifndef COUNTER_WRAP_PULSE_EN
  assign {w0b, w0s, w1b, w1s, w2b, w2s} = '0;
`endif

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check("cnt0_beh", 64'(o0b), F0 + k0 * S0);
    check("cnt0_str", 64'(o0s), F0 + k0 * S0);
    check("cnt1_beh", 64'(o1b), F1 + k1 * S1);
    check("cnt1_str", 64'(o1s), F1 + k1 * S1);
    check("cnt2_beh", 64'(o2b), F2 + k2 * S2);
    check("cnt2_str", 64'(o2s), F2 + k2 * S2);
`ifdef COUNTER_WRAP_PULSE_EN
    check("wrap0_beh", 64'(w0b), 64'(xw0));
    check("wrap0_str", 64'(w0s), 64'(xw0));
    check("wrap1_beh", 64'(w1b), 64'(xw1));
    check("wrap1_str", 64'(w1s), 64'(xw1));
    check("wrap2_beh", 64'(w2b), 64'(xw2));
    check("wrap2_str", 64'(w2s), 64'(xw2));
`endif
  endtask

  // One clock: apply inputs, advance the model by pass index, check after the edge
  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    #1;
    xw0 = !r && e && (k0 == K0);
    xw1 = !r && e && (k1 == K1);
    xw2 = !r && e && (k2 == K2);
    if (r) begin
      k0 = 0; k1 = 0; k2 = 0;
    end else if (e) begin
      k0 = (k0 == K0) ? 0 : k0 + 1;
      k1 = (k1 == K1) ? 0 : k1 + 1;
      k2 = (k2 == K2) ? 0 : k2 + 1;
    end
    check_all();
  endtask

  initial begin
    // Power-up value before any reset or clock edge
    #1;
    check_all();

    repeat (2) step(1'b1, 1'b0);
    repeat (300) step(1'b0, 1'b1);

    // Reset with enable high when the default counter reads 100
    for (int i = 0; i < 300 && k0 != 100; i++) step(1'b0, 1'b1);
    check("reach_100", 64'(o0b), 64'd100);
    repeat (3) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);

    // Enable toggling 1,0,0,1,1 starting from out=10
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("toggle_end", 64'(o0s), 64'd13);

    // Random enable with occasional reset
    repeat (3000) step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/range_counter.md
Name: range_counter

Overview:
- Synchronous up-counter stepping from COUNT_FROM toward COUNT_TO in increments of STEP, wrapping back to COUNT_FROM.
- Used as a generic primitive for address generators, frame and sample counters, and timing strobes.
- ARCHITECTURE selects between two cycle-identical implementations.

Parameters:
ARCHITECTURE, "BEHAVIORAL", implementation style: "BEHAVIORAL" (inferred adder and compare) or "STRUCTURAL" (explicit DATA_WIDTH+1-bit ripple adder plus comparator, registered); any other string is an elaboration error
DATA_WIDTH, 8, width of out in bits, 1..64
COUNT_FROM, 0, reset and wrap value
COUNT_TO, 255, highest value reached before wrap (inclusive)
STEP, 1, increment per enabled cycle, >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  count enable
out  output  DATA_WIDTH  current count, registered

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- All state updates occur on the rising edge of clk.
- Priority: rst > en.
- rst=1 at a rising edge: out <= COUNT_FROM, regardless of en.
- Power-up or initial register value: COUNT_FROM, so the counter counts correctly even if rst is never asserted.
- rst=0, en=0: out holds.
- rst=0, en=1: compute sum = out + STEP in DATA_WIDTH+1 bits.
  - sum > COUNT_TO: out <= COUNT_FROM (wrap).
  - Otherwise: out <= sum[DATA_WIDTH-1:0].
- If STEP does not divide (COUNT_TO - COUNT_FROM), the last value before wrap is the largest COUNT_FROM + k*STEP <= COUNT_TO. No partial step and no modulo carry into the next pass.
- Latency: out reflects an enable one cycle after the edge that samples it. No combinational path from inputs to out.
- Full-range case (COUNT_FROM=0, COUNT_TO=2^DATA_WIDTH-1, STEP=1): free-running binary counter, 255 -> 0 for 8 bits. The extra sum bit prevents false non-wrap on overflow.
- Reset mid-count: takes effect on the same edge. Count resumes from COUNT_FROM on the next enabled edge.
- out is constrained by construction to the range COUNT_FROM..COUNT_TO.
- Elaboration checks (fatal error on violation):
  - COUNT_FROM <= COUNT_TO
  - COUNT_TO < 2^DATA_WIDTH
  - STEP >= 1
  - STEP <= 2^DATA_WIDTH - 1
- Both architectures must produce bit-identical out on every cycle for identical stimulus.

Optional Feature:
- Macro: COUNTER_WRAP_PULSE_EN.
- When defined, adds output port wrap (1 bit, registered).
  - wrap=1 for exactly the one cycle in which out has just been loaded with COUNT_FROM due to a wrap, i.e. an enabled edge where sum > COUNT_TO.
  - wrap=0 after reset. Reset loading COUNT_FROM does not raise wrap.
  - wrap=0 whenever en was low on the previous edge.
- When not defined: the port does not exist and no logic is generated. out behaviour is identical in both builds.

Test Plan:
- Defaults, rst=1 for 2 cycles then en=1 held for 300 cycles -> out = 0,1,2,...,255,0,1,...; wrap after 255 to 0 with no skipped or repeated value.
- Defaults, en toggled 1,0,0,1,1 from out=10 -> out sequence 11,11,11,12,13; holds while en=0.
- COUNT_FROM=3, COUNT_TO=20, STEP=5, en=1 -> out = 3,8,13,18,3,8...; 18+5=23 > 20 wraps to 3. With COUNTER_WRAP_PULSE_EN, wrap high only on the cycle out returns to 3.
- DATA_WIDTH=4, COUNT_FROM=0, COUNT_TO=15, STEP=3 -> 0,3,6,9,12,15,0; no overflow aliasing (15+3=18 detected via extra bit).
- Defaults, assert rst=1 with en=1 when out=100 -> next out=0; out stays 0 while rst=1; resumes 1,2,... after release.
- Run every scenario with ARCHITECTURE="BEHAVIORAL" and "STRUCTURAL" -> out traces identical cycle-for-cycle. ARCHITECTURE="FOO" -> elaboration fails.
